sram_port_arbiter: RTL and testbench

//  Shares the single SRAM command port between three requesters: boot copier (P0),
//  CPU data port (P1) and CPU instruction fetch (P2). While boot_done=0 only P0 is

---
 rtl/sram_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Three-way arbiter for the single SRAM command port: boot copier only during boot,
// then round-robin between CPU data and instruction fetch.
module sram_port_arbiter #(
  parameter int unsigned AW      = 22,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_boot_done,
  input  logic          i_p0_req,
  input  logic          i_p0_we,
  input  logic [AW-1:0] i_p0_addr,
  input  logic [DW-1:0] i_p0_wdata,
  output logic          o_p0_ack,
  output logic          o_p0_err,
  output logic [DW-1:0] o_p0_rdata,
  input  logic          i_p1_req,
  input  logic          i_p1_we,
  input  logic [AW-1:0] i_p1_addr,
  input  logic [DW-1:0] i_p1_wdata,
  output logic          o_p1_ack,
  output logic          o_p1_err,
  output logic [DW-1:0] o_p1_rdata,
  input  logic          i_p2_req,
  input  logic          i_p2_we,
  input  logic [AW-1:0] i_p2_addr,
  input  logic [DW-1:0] i_p2_wdata,
  output logic          o_p2_ack,
  output logic          o_p2_err,
  output logic [DW-1:0] o_p2_rdata,
  output logic          o_mem_cs,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ready,
  output logic          o_busy
);

  typedef enum logic [2:0] {StIdle, StIssue, StGap, StWait, StDone} state_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_e        r_state, w_state_d;
  logic [1:0]    r_win, r_rr_last, w_gid;
  logic          r_we, r_err, w_err_d, w_grant, w_cap;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [7:0]    r_tmo_cnt, w_tmo_d;
  logic [DW-1:0] r_rdata0, r_rdata1, r_rdata2;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_done;

  always_comb begin
    w_state_d = r_state;
    w_grant   = 1'b0;
    w_gid     = r_win;
    w_cap     = 1'b0;
    w_err_d   = r_err;
    w_tmo_d   = r_tmo_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_mem_ready) begin
          if (!i_boot_done) begin
            if (i_p0_req) begin
              w_grant = 1'b1;
              w_gid   = 2'd0;
            end
          end else if (i_p1_req && i_p2_req) begin
            // Contention: the port that did not win last time goes first.
            w_grant = 1'b1;
            w_gid   = (r_rr_last == 2'd1) ? 2'd2 : 2'd1;
          end else if (i_p1_req) begin
            w_grant = 1'b1;
            w_gid   = 2'd1;
          end else if (i_p2_req) begin
            w_grant = 1'b1;
            w_gid   = 2'd2;
          end
        end
        if (w_grant) w_state_d = StIssue;
      end
      StIssue: begin
        w_tmo_d   = 8'd0;
        w_state_d = StGap;
      end
      StGap: w_state_d = StWait;
      StWait: begin
        if (i_mem_ready) begin
          w_cap     = ~r_we;
          w_err_d   = 1'b0;
          w_state_d = StDone;
        end else if (r_tmo_cnt == TmoLast) begin
          w_err_d   = 1'b1;
          w_state_d = StDone;
        end else begin
          w_tmo_d = r_tmo_cnt + 8'd1;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_sel_we    = i_p0_we;
    w_sel_addr  = i_p0_addr;
    w_sel_wdata = i_p0_wdata;
    case (w_gid)
      2'd1: begin
        w_sel_we    = i_p1_we;
        w_sel_addr  = i_p1_addr;
        w_sel_wdata = i_p1_wdata;
      end
      2'd2: begin
        w_sel_we    = i_p2_we;
        w_sel_addr  = i_p2_addr;
        w_sel_wdata = i_p2_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_win     <= 2'd0;
      r_rr_last <= 2'd2;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_tmo_cnt <= 8'd0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rdata2  <= '0;
    end else begin
      r_state   <= w_state_d;
      r_err     <= w_err_d;
      r_tmo_cnt <= w_tmo_d;
      // The command latch doubles as the SRAM address/data outputs.
      if (w_grant) begin
        r_win   <= w_gid;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == StDone && r_win != 2'd0) r_rr_last <= r_win;
      if (w_cap) begin
        case (r_win)
          2'd0:    r_rdata0 <= i_mem_rdata;
          2'd1:    r_rdata1 <= i_mem_rdata;
          default: r_rdata2 <= i_mem_rdata;
        endcase
      end
    end
  end

  assign w_done      = (r_state == StDone);
  assign o_mem_cs    = (r_state == StIssue);
  assign o_mem_we    = o_mem_cs & r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_busy      = (r_state != StIdle);
  assign o_p0_ack    = w_done & (r_win == 2'd0);
  assign o_p1_ack    = w_done & (r_win == 2'd1);
  assign o_p2_ack    = w_done & (r_win == 2'd2);
  assign o_p0_err    = o_p0_ack & r_err;
  assign o_p1_err    = o_p1_ack & r_err;
  assign o_p2_err    = o_p2_ack & r_err;
  assign o_p0_rdata  = r_rdata0;
  assign o_p1_rdata  = r_rdata1;
  assign o_p2_rdata  = r_rdata2;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small SRAM controller model
// (ready drops after cs, returns after a programmable delay or never).
module tb_sram_port_arbiter;

  localparam int AW = 22;
  localparam int DW = 32;

  logic          clk, rst, boot_done;
  logic          p0_req, p0_we, p1_req, p1_we, p2_req, p2_we;
  logic [AW-1:0] p0_addr, p1_addr, p2_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p2_wdata;
  logic          p0_ack, p0_err, p1_ack, p1_err, p2_ack, p2_err;
  logic [DW-1:0] p0_rdata, p1_rdata, p2_rdata;
  logic          mem_cs, mem_we, mem_ready, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .i_boot_done(boot_done),
    .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .o_p0_ack(p0_ack), .o_p0_err(p0_err), .o_p0_rdata(p0_rdata),
    .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .o_p1_ack(p1_ack), .o_p1_err(p1_err), .o_p1_rdata(p1_rdata),
    .i_p2_req(p2_req), .i_p2_we(p2_we), .i_p2_addr(p2_addr), .i_p2_wdata(p2_wdata),
    .o_p2_ack(p2_ack), .o_p2_err(p2_err), .o_p2_rdata(p2_rdata),
    .o_mem_cs(mem_cs), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM controller model, indexed by the low 5 address bits.
  logic [DW-1:0] mem [32];
  logic [4:0]    m_addr;
  int            lat = 2;
  bit            hang = 1'b0;
  int            mcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b1;
      mem_rdata <= '0;
      mcnt      <= 0;
      m_addr    <= '0;
      mem[1]    <= 32'h1111_0001;
      mem[2]    <= 32'h2222_0002;
      mem[3]    <= 32'h3333_0003;
      mem[4]    <= 32'h4444_0004;
      mem[5]    <= 32'h5555_0005;
      mem[31]   <= 32'h1234_5678;
    end else if (mem_cs) begin
      mem_ready <= 1'b0;
      mcnt      <= lat;
      m_addr    <= mem_addr[4:0];
      if (mem_we) mem[mem_addr[4:0]] <= mem_wdata;
    end else if (!mem_ready && !hang) begin
      if (mcnt == 0) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[m_addr];
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // Event monitor: strobes and acks seen at each active edge.
  int            cyc = 0, cs_cnt = 0, cs_cyc = 0, ack0 = 0, ack1 = 0, ack2 = 0, ack1_cyc = 0;
  logic          cs_we;
  logic [AW-1:0] cs_addr;
  logic [DW-1:0] cs_wdata;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_cs) begin
      cs_cnt   = cs_cnt + 1;
      cs_cyc   = cyc;
      cs_we    = mem_we;
      cs_addr  = mem_addr;
      cs_wdata = mem_wdata;
    end
    if (p0_ack) ack0 = ack0 + 1;
    if (p1_ack) begin
      ack1     = ack1 + 1;
      ack1_cyc = cyc;
    end
    if (p2_ack) ack2 = ack2 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int port, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      case (port)
        0:       got = p0_ack;
        1:       got = p1_ack;
        default: got = p2_ack;
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    boot_done = 1'b0;
    {p0_req, p0_we, p1_req, p1_we, p2_req, p2_we} = '0;
    {p0_addr, p1_addr, p2_addr} = '0;
    {p0_wdata, p1_wdata, p2_wdata} = '0;
    repeat (3) tick();
    checks++;
    if ({busy, mem_cs, mem_we} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/cs/we=%b want 000", {busy, mem_cs, mem_we});
    end
    checks++;
    if ({p0_ack, p0_err, p1_ack, p1_err, p2_ack, p2_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ack: ack/err=%b want 0", {p0_ack, p0_err, p1_ack, p1_err, p2_ack, p2_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, p0_rdata, p1_rdata, p2_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h/%h/%h want 0",
               mem_addr, mem_wdata, p0_rdata, p1_rdata, p2_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_boot_write();
    logic [31:0] a32;
    int c0, a1;
    bit got;
    a32 = 32'h0040_0000;
    c0 = cs_cnt;
    a1 = ack1;
    lat = 2;
    boot_done = 1'b0;
    p0_we = 1'b1; p0_addr = a32[AW-1:0]; p0_wdata = 32'hDEAD_BEEF; p0_req = 1'b1;
    p1_we = 1'b0; p1_addr = 22'd1; p1_req = 1'b1;
    wait_ack(0, 30, got);
    p0_req = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL boot_ack: ack seen=%0d want 1", got); end
    checks++;
    if (p0_err !== 1'b0) begin errors++; $display("FAIL boot_err: err=%b want 0", p0_err); end
    checks++;
    if (cs_cnt - c0 !== 1 || cs_we !== 1'b1 || cs_addr !== 22'h0 || cs_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL boot_cmd: cs=%0d we=%b addr=%h wdata=%h want 1/1/000000/deadbeef",
               cs_cnt - c0, cs_we, cs_addr, cs_wdata);
    end
    tick();
    checks++;
    if (p0_ack !== 1'b0) begin errors++; $display("FAIL boot_ack_pulse: ack=%b want 0", p0_ack); end
    checks++;
    if (p0_rdata !== 32'h0) begin errors++; $display("FAIL boot_wr_rdata: rdata=%h want 0", p0_rdata); end
    repeat (12) tick();
    checks++;
    if (ack1 !== a1) begin errors++; $display("FAIL boot_p1_blocked: p1 acks=%0d want %0d", ack1, a1); end
    p1_req = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_port [4] = '{1, 2, 1, 2};
    logic [31:0] exp_data [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    int n, port, a0;
    logic [31:0] data;
    a0 = ack0;
    boot_done = 1'b1;
    p0_we = 1'b0; p0_addr = 22'd2; p0_req = 1'b1;
    p1_we = 1'b0; p1_addr = 22'd1; p1_req = 1'b1;
    p2_we = 1'b0; p2_addr = 22'd2; p2_req = 1'b1;
    n = 0;
    for (int c = 0; c < 120 && n < 4; c++) begin
      tick();
      if (p1_ack || p2_ack) begin
        port = p1_ack ? 1 : 2;
        data = p1_ack ? p1_rdata : p2_rdata;
        checks++;
        if (port !== exp_port[n]) begin
          errors++;
          $display("FAIL rr_order[%0d]: port=%0d want %0d", n, port, exp_port[n]);
        end
        checks++;
        if (data !== exp_data[n]) begin
          errors++;
          $display("FAIL rr_rdata[%0d]: rdata=%h want %h", n, data, exp_data[n]);
        end
        if (port == 1) p1_addr = 22'd3; else p2_addr = 22'd4;
        if (n >= 2) begin
          if (port == 1) p1_req = 1'b0; else p2_req = 1'b0;
        end
        n++;
      end
    end
    p1_req = 1'b0; p2_req = 1'b0;
    checks++;
    if (n !== 4) begin errors++; $display("FAIL rr_count: grants=%0d want 4", n); end
    repeat (3) tick();
    checks++;
    if (ack0 !== a0) begin errors++; $display("FAIL rr_p0_locked: p0 acks=%0d want %0d", ack0, a0); end
    p0_req = 1'b0;
  endtask

  task automatic test_read_hold();
    bit got;
    p2_we = 1'b0; p2_addr = 22'h3F_FFFF; p2_req = 1'b1;
    wait_ack(2, 30, got);
    p2_req = 1'b0;
    checks++;
    if (!got || p2_rdata !== 32'h1234_5678 || p2_err !== 1'b0) begin
      errors++;
      $display("FAIL hold_read: ack=%0d rdata=%h err=%b want 1/12345678/0", got, p2_rdata, p2_err);
    end
    p1_we = 1'b1; p1_addr = 22'h10; p1_wdata = 32'hCAFE_F00D; p1_req = 1'b1;
    wait_ack(1, 30, got);
    p1_req = 1'b0;
    checks++;
    if (!got || cs_we !== 1'b1 || cs_addr !== 22'h10 || cs_wdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL hold_write_cmd: ack=%0d we=%b addr=%h wdata=%h want 1/1/000010/cafef00d",
               got, cs_we, cs_addr, cs_wdata);
    end
    checks++;
    if (p2_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL hold_p2_rdata: rdata=%h want 12345678", p2_rdata);
    end
    checks++;
    if (p1_rdata !== 32'h3333_0003) begin
      errors++;
      $display("FAIL hold_p1_wr_rdata: rdata=%h want 33330003", p1_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit got;
    hang = 1'b1;
    p1_we = 1'b0; p1_addr = 22'd5; p1_req = 1'b1;
    wait_ack(1, 40, got);
    p1_req = 1'b0;
    checks++;
    if (!got || p1_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_err: ack=%0d err=%b want 1/1", got, p1_err);
    end
    checks++;
    if (p1_rdata !== 32'h3333_0003) begin
      errors++;
      $display("FAIL tmo_rdata: rdata=%h want 33330003", p1_rdata);
    end
    tick();
    // ISSUE, GAP, eight WAIT cycles, then DONE.
    checks++;
    if (ack1_cyc - cs_cyc !== 10) begin
      errors++;
      $display("FAIL tmo_latency: cs->ack=%0d want 10", ack1_cyc - cs_cyc);
    end
    p2_we = 1'b0; p2_addr = 22'd2; p2_req = 1'b1;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL tmo_no_grant: busy=%b want 0", busy); end
    hang = 1'b0;
    wait_ack(2, 40, got);
    p2_req = 1'b0;
    checks++;
    if (!got || p2_rdata !== 32'h2222_0002 || p2_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_recover: ack=%0d rdata=%h err=%b want 1/22220002/0", got, p2_rdata, p2_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit got;
    int a1;
    lat = 4;
    p1_we = 1'b0; p1_addr = 22'd1; p1_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = mem_cs;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rstmid_issue: cs seen=%0d want 1", got); end
    tick();
    tick();
    a1 = ack1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, mem_cs, p1_ack, p1_err} !== 4'b0 || mem_addr !== '0 || p1_rdata !== '0 ||
        p2_rdata !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: busy/cs/ack/err=%b addr=%h rdata1=%h rdata2=%h want 0",
               {busy, mem_cs, p1_ack, p1_err}, mem_addr, p1_rdata, p2_rdata);
    end
    p1_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    checks++;
    if (ack1 !== a1) begin errors++; $display("FAIL rstmid_no_ack: p1 acks=%0d want %0d", ack1, a1); end
    lat = 2;
    p1_req = 1'b1;
    wait_ack(1, 30, got);
    p1_req = 1'b0;
    checks++;
    if (!got || p1_rdata !== 32'h1111_0001 || p1_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_retry: ack=%0d rdata=%h err=%b want 1/11110001/0", got, p1_rdata, p1_err);
    end
    tick();
  endtask

  task automatic test_boot_switch();
    bit got;
    int a0, a1;
    boot_done = 1'b0;
    p0_we = 1'b0; p0_addr = 22'd0; p0_req = 1'b1;
    p1_we = 1'b0; p1_addr = 22'd1; p1_req = 1'b1;
    p2_we = 1'b0; p2_addr = 22'd2; p2_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = mem_cs;
    end
    boot_done = 1'b1;
    wait_ack(0, 30, got);
    checks++;
    if (!got || p0_rdata !== 32'hDEAD_BEEF || p0_err !== 1'b0) begin
      errors++;
      $display("FAIL switch_p0: ack=%0d rdata=%h err=%b want 1/deadbeef/0", got, p0_rdata, p0_err);
    end
    a0 = ack0 + 1;
    a1 = ack1;
    p0_addr = 22'd3;
    // rr_last is P1 from the previous access, so P2 takes the first run-phase grant.
    wait_ack(2, 30, got);
    p1_req = 1'b0; p2_req = 1'b0;
    checks++;
    if (!got || p2_rdata !== 32'h2222_0002 || ack1 !== a1) begin
      errors++;
      $display("FAIL switch_next: p2 ack=%0d rdata=%h p1 acks=%0d want 1/22220002/%0d",
               got, p2_rdata, ack1, a1);
    end
    repeat (12) tick();
    checks++;
    if (ack0 !== a0) begin errors++; $display("FAIL switch_p0_locked: p0 acks=%0d want %0d", ack0, a0); end
    p0_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_boot_write();
    test_round_robin();
    test_read_hold();
    test_timeout();
    test_reset_mid();
    test_boot_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1);
  end

endmodule
